// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv_pkg                                                    |
// | Purpose  : Shared RISC-V constants and types for the writeback path  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rv_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] reg_idx_t;

   // Load funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/wb_write_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_write_ctrl_if                                          |
// | Purpose  : ALU/LSU/issue/decode/register-file signals of the         |
// |            writeback controller                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface wb_write_ctrl_if #(
   parameter int XLEN = rv_pkg::XLEN
);
   import rv_pkg::*;

   logic            alu_valid;
   reg_idx_t        alu_rd;
   logic [XLEN-1:0] alu_data;

   logic            lsu_valid;
   logic            lsu_ready;
   reg_idx_t        lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic [2:0]      lsu_funct3;
   logic [1:0]      lsu_addr_lo;

   logic            iss_valid;
   reg_idx_t        iss_rd;

   reg_idx_t        rs1;
   reg_idx_t        rs2;
   logic            haz1;
   logic            haz2;
   logic [5:0]      pend_cnt;

   logic            WE3;
   reg_idx_t        A3;
   logic [XLEN-1:0] WD3;

   // Producer / consumer side of the controller (pipeline around it)
   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
      output iss_valid, iss_rd, rs1, rs2,
      input  lsu_ready, haz1, haz2, pend_cnt, WE3, A3, WD3
   );

   // The controller itself
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_addr_lo,
      input  iss_valid, iss_rd, rs1, rs2,
      output lsu_ready, haz1, haz2, pend_cnt, WE3, A3, WD3
   );

endinterface
`default_nettype wire

// File: rtl/wb_load_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_load_queue                                             |
// | Purpose  : Small FIFO for load responses with registered full/empty  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module wb_load_queue #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int           AW         = $clog2(DEPTH);
   localparam logic [AW:0]  c_FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  c_CNT_ONE  = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   // A push into a full queue is legal only when the head leaves the same cycle
   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + c_CNT_ONE;
         2'b01:   count_d = count_q - c_CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are don't-care while the entry is not counted
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == c_FULL_CNT);
         empty_q <= (count_d == '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_write_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_write_ctrl                                             |
// | Purpose  : Register-file write port arbiter (ALU over buffered       |
// |            loads), load extension and RAW pending scoreboard         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module wb_write_ctrl #(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int NREG     = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   wb_write_ctrl_if.slave bus
);
   import rv_pkg::*;

   localparam int c_ENTRY_W = $bits(reg_idx_t) + XLEN;

   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [XLEN-1:0]      ld_ext;

   logic                 lq_push, lq_pop, lq_full, lq_empty;
   logic [c_ENTRY_W-1:0] lq_head;
   reg_idx_t             head_rd;
   logic [XLEN-1:0]      head_data;

   logic                 we3_q, we3_d;
   reg_idx_t             a3_q, a3_d;
   logic [XLEN-1:0]      wd3_q, wd3_d;

   logic [NREG-1:0]      pend_q, pend_d;
   logic [5:0]           pend_cnt_q, pend_cnt_d;

   // Extend the raw load word by type and byte offset before it is queued
   always_comb begin
      ld_byte = bus.lsu_data[{bus.lsu_addr_lo, 3'b000} +: 8];
      ld_half = bus.lsu_data[{bus.lsu_addr_lo[1], 4'b0000} +: 16];
      case (bus.lsu_funct3)
         LB:      ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         LH:      ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
         LBU:     ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
         LHU:     ld_ext = {{(XLEN-16){1'b0}}, ld_half};
         LW:      ld_ext = bus.lsu_data;
         default: ld_ext = bus.lsu_data;
      endcase
   end

   // The queue head only drains in cycles the ALU leaves the port free
   assign lq_push       = bus.lsu_valid && !lq_full;
   assign lq_pop        = !bus.alu_valid && !lq_empty;
   assign bus.lsu_ready = !lq_full;
   assign {head_rd, head_data} = lq_head;

   wb_load_queue #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk         (clk),
      .rst         (rst),
      .push_i      (lq_push),
      .push_data_i ({bus.lsu_rd, ld_ext}),
      .pop_i       (lq_pop),
      .pop_data_o  (lq_head),
      .full_o      (lq_full),
      .empty_o     (lq_empty)
   );

   // Select the source for next cycle's write; x0 targets are consumed silently
   always_comb begin
      we3_d = 1'b0;
      a3_d  = '0;
      wd3_d = '0;
      if (bus.alu_valid) begin
         we3_d = (bus.alu_rd != '0);
         a3_d  = bus.alu_rd;
         wd3_d = bus.alu_data;
      end else if (!lq_empty) begin
         we3_d = (head_rd != '0);
         a3_d  = head_rd;
         wd3_d = head_data;
      end
   end

   // Registered register-file write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we3_q <= 1'b0;
         a3_q  <= '0;
         wd3_q <= '0;
      end else begin
         we3_q <= we3_d;
         a3_q  <= a3_d;
         wd3_q <= wd3_d;
      end
   end

   assign bus.WE3 = we3_q;
   assign bus.A3  = a3_q;
   assign bus.WD3 = wd3_q;

   // Clear on commit, then set on issue so a newer producer keeps the bit
   always_comb begin
      pend_d = pend_q;
      if (we3_q) pend_d[a3_q] = 1'b0;
      if (bus.iss_valid && (bus.iss_rd != '0)) pend_d[bus.iss_rd] = 1'b1;
      pend_cnt_d = '0;
      for (int i = 0; i < NREG; i++) pend_cnt_d = pend_cnt_d + 6'(pend_d[i]);
   end

   // Scoreboard state and its population count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign bus.pend_cnt = pend_cnt_q;

   // A register being written this cycle is no longer a hazard for decode
   assign bus.haz1 = pend_q[bus.rs1] && (bus.rs1 != '0) && !(we3_q && (a3_q == bus.rs1));
   assign bus.haz2 = pend_q[bus.rs2] && (bus.rs2 != '0) && !(we3_q && (a3_q == bus.rs2));

endmodule
`default_nettype wire

// File: doc/wb_write_ctrl.md
Name: wb_write_ctrl

Overview:
Writeback-side controller for the register file write port (WE3/A3/WD3).
- Merges two producers into the single write port: the ALU result (fixed pipeline slot, never stalled) and the load/store unit load response (valid/ready handshake, buffered).
- Performs load sign/zero extension.
- Keeps a per-register pending scoreboard that decode queries for read-after-write hazards on rs1/rs2.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers.
- LQ_DEPTH, 4, load-response buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load response valid
- lsu_ready  out  1  load response accepted when lsu_valid && lsu_ready
- lsu_rd  in  5  load destination register
- lsu_data  in  XLEN  raw aligned memory word
- lsu_funct3  in  3  load type
- lsu_addr_lo  in  2  byte offset of load address
- iss_valid  in  1  instruction issued with a destination register
- iss_rd  in  5  destination of issued instruction
- rs1  in  5  decode source 1
- rs2  in  5  decode source 2
- haz1  out  1  rs1 pending
- haz2  out  1  rs2 pending
- pend_cnt  out  6  number of pending registers
- WE3  out  1  register-file write enable
- A3  out  5  register-file write address
- WD3  out  XLEN  register-file write data

Behaviour:
- Reset (async, rst=1): WE3=0, A3=0, WD3=0, load queue empty, lsu_ready=1, scoreboard all clear, pend_cnt=0, haz1=haz2=0.
- Write port timing:
  - WE3/A3/WD3 are registered.
  - A source selected in cycle N appears on the port in cycle N+1 for exactly one cycle.
  - WE3=0 when nothing is selected.
- Arbitration:
  - ALU has absolute priority. A valid ALU result is written in the next cycle unconditionally.
  - The load-queue head drains only in cycles with alu_valid=0.
- Load queue:
  - FIFO of LQ_DEPTH entries holding {rd, extended data}.
  - lsu_ready = !full.
  - Push when lsu_valid && lsu_ready.
  - Extension is applied before push:
    - funct3=000 LB: sign-extend the byte at lsu_addr_lo.
    - 001 LH: sign-extend the halfword at lsu_addr_lo[1].
    - 010 LW: full word.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend halfword.
    - Any other value: full word.
  - Push and pop in the same cycle are allowed when full. The count is unchanged, but lsu_ready stays 0 that cycle because it is derived from registered full.
  - Pointers wrap modulo LQ_DEPTH.
- x0: a write with rd=0 is consumed (dequeued/accepted) but drives WE3=0. The scoreboard never marks x0.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pend[iss_rd] at the clock edge.
  - A write committed in cycle N+1 (WE3=1) clears pend[A3] at that edge.
  - Set and clear of the same register in the same cycle: set wins, because a newer producer exists.
  - haz1 = pend[rs1] && rs1!=0, combinational. haz2 likewise for rs2.
  - Same-cycle bypass: if WE3=1 && A3==rs, haz for that rs is 0, since the register file is written this edge. Decode forwarding is outside this block.
  - pend_cnt = popcount of pend, registered alongside it.
- Reset mid-operation: queue contents are discarded, no writes occur, and the scoreboard clears immediately.

Decomposition:
- Shared package rv_pkg:
  - Load funct3 constants: LB, LH, LW, LBU, LHU.
  - XLEN.
  - Register-index typedef (5 bits).
- One sub-module: wb_load_queue (parameterised FIFO with registered full/empty). Extension logic and scoreboard stay in the top.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF → next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the following cycle WE3=0.
- lsu_valid with funct3=000, addr_lo=2, data=0x12F45678, rd=7, no ALU traffic → WD3=0xFFFFFFF4, A3=7, two cycles after acceptance. Repeat with funct3=100 → WD3=0x000000F4.
- ALU valid every cycle for 6 cycles with 5 loads offered → lsu_ready drops after 4 accepted, no load writes occur during the ALU burst, then the 4 loads drain in order on consecutive cycles.
- iss_rd=3, then rs1=3 → haz1=1 and pend_cnt=1. When the ALU write to x3 appears on WE3 → haz1=0 that cycle, pend_cnt=0 the next.
- Same cycle: iss_rd=9 and a commit of x9 → pend[9] stays 1. Write to rd=0 → WE3 never asserts, and haz for rs1=0 is always 0.
- Assert rst with 3 queued loads and 2 pending registers → WE3=0 immediately, queue empty, lsu_ready=1, pend_cnt=0, and no stale writes after rst deasserts.
